// File: rtl/fu_issue_scheduler_if.sv
// Dispatch, wakeup and issue signals shared by the scheduler and its environment.
interface fu_issue_scheduler_if #(
    parameter int NUM_FU  = 3,
    parameter int ENTRY_W = 139
);
    logic                      flush;
    logic                      disp_valid;
    logic [ENTRY_W-1:0]        disp_entry;
    logic                      disp_rs1_rdy;
    logic                      disp_rs2_rdy;
    logic                      disp_ready;
    logic                      cdb_valid;
    logic [5:0]                cdb_tag;
    logic [31:0]               cdb_value;
    logic [NUM_FU-1:0]         fu_busy;
    logic [ENTRY_W*NUM_FU-1:0] fu_entry;
    logic [NUM_FU-1:0]         fu_enable;
    logic [4:0]                count;

    modport master (
        output flush, disp_valid, disp_entry, disp_rs1_rdy, disp_rs2_rdy,
               cdb_valid, cdb_tag, cdb_value, fu_busy,
        input  disp_ready, fu_entry, fu_enable, count
    );

    modport slave (
        input  flush, disp_valid, disp_entry, disp_rs1_rdy, disp_rs2_rdy,
               cdb_valid, cdb_tag, cdb_value, fu_busy,
        output disp_ready, fu_entry, fu_enable, count
    );
endinterface

// File: rtl/fu_issue_scheduler.sv
// Collapsing issue queue: captures operands from the result broadcast and issues
// up to NUM_FU oldest ready entries per cycle, one registered slice per functional unit.
module fu_issue_scheduler #(
    parameter int DEPTH   = 8,
    parameter int NUM_FU  = 3,
    parameter int ENTRY_W = 139
) (
    input  logic                 clk,
    input  logic                 reset,
    fu_issue_scheduler_if.slave  bus
);
    localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    logic               r_valid   [DEPTH];
    logic [ENTRY_W-1:0] r_entry   [DEPTH];
    logic               r_rs1_rdy [DEPTH];
    logic               r_rs2_rdy [DEPTH];
    logic [4:0]         r_count;
    logic [ENTRY_W-1:0] r_fu_entry [NUM_FU];
    logic [NUM_FU-1:0]  r_fu_enable;

    logic               w_taken   [DEPTH];
    logic               w_sel_vld [NUM_FU];
    logic [IDX_W-1:0]   w_sel_idx [NUM_FU];
    logic               w_accept;

    logic [ENTRY_W-1:0] w_wk_entry [DEPTH];
    logic               w_wk_rs1   [DEPTH];
    logic               w_wk_rs2   [DEPTH];
    logic [ENTRY_W-1:0] w_disp_entry;
    logic               w_disp_rs1;
    logic               w_disp_rs2;

    logic               w_nx_valid [DEPTH];
    logic [ENTRY_W-1:0] w_nx_entry [DEPTH];
    logic               w_nx_rs1   [DEPTH];
    logic               w_nx_rs2   [DEPTH];
    logic [IDX_W:0]     w_wr;
    logic [4:0]         w_nx_count;

    assign bus.disp_ready = (r_count < DEPTH_C);
    assign bus.count      = r_count;
    assign bus.fu_enable  = r_fu_enable;
    assign w_accept       = bus.disp_valid && bus.disp_ready;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_fu_out
        assign bus.fu_entry[g*ENTRY_W +: ENTRY_W] = r_fu_entry[g];
    end

    // Select uses only registered ready bits, so a wakeup is visible one cycle later.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) w_taken[i] = 1'b0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            w_sel_vld[k] = 1'b0;
            w_sel_idx[k] = '0;
            if (!bus.fu_busy[k]) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (!w_sel_vld[k] && !w_taken[i] && r_valid[i] && r_rs1_rdy[i] && r_rs2_rdy[i]) begin
                        w_sel_vld[k] = 1'b1;
                        w_sel_idx[k] = IDX_W'(i);
                        w_taken[i]   = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_wk_entry[i] = r_entry[i];
            w_wk_rs1[i]   = r_rs1_rdy[i];
            w_wk_rs2[i]   = r_rs2_rdy[i];
            if (bus.cdb_valid && r_valid[i] && !r_rs1_rdy[i] && r_entry[i][115:110] == bus.cdb_tag) begin
                w_wk_entry[i][109:78] = bus.cdb_value;
                w_wk_rs1[i]           = 1'b1;
            end
            if (bus.cdb_valid && r_valid[i] && !r_rs2_rdy[i] && r_entry[i][77:72] == bus.cdb_tag) begin
                w_wk_entry[i][71:40] = bus.cdb_value;
                w_wk_rs2[i]          = 1'b1;
            end
        end
        w_disp_entry = bus.disp_entry;
        w_disp_rs1   = bus.disp_rs1_rdy;
        w_disp_rs2   = bus.disp_rs2_rdy;
        if (bus.cdb_valid && !bus.disp_rs1_rdy && bus.disp_entry[115:110] == bus.cdb_tag) begin
            w_disp_entry[109:78] = bus.cdb_value;
            w_disp_rs1           = 1'b1;
        end
        if (bus.cdb_valid && !bus.disp_rs2_rdy && bus.disp_entry[77:72] == bus.cdb_tag) begin
            w_disp_entry[71:40] = bus.cdb_value;
            w_disp_rs2          = 1'b1;
        end
    end

    // Survivors pack down in age order; the new entry lands right after them.
    always_comb begin
        w_wr = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_nx_valid[i] = 1'b0;
            w_nx_entry[i] = '0;
            w_nx_rs1[i]   = 1'b0;
            w_nx_rs2[i]   = 1'b0;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && !w_taken[i]) begin
                w_nx_valid[w_wr[IDX_W-1:0]] = 1'b1;
                w_nx_entry[w_wr[IDX_W-1:0]] = w_wk_entry[i];
                w_nx_rs1[w_wr[IDX_W-1:0]]   = w_wk_rs1[i];
                w_nx_rs2[w_wr[IDX_W-1:0]]   = w_wk_rs2[i];
                w_wr = w_wr + {{IDX_W{1'b0}}, 1'b1};
            end
        end
        if (w_accept) begin
            w_nx_valid[w_wr[IDX_W-1:0]] = 1'b1;
            w_nx_entry[w_wr[IDX_W-1:0]] = w_disp_entry;
            w_nx_rs1[w_wr[IDX_W-1:0]]   = w_disp_rs1;
            w_nx_rs2[w_wr[IDX_W-1:0]]   = w_disp_rs2;
        end
        w_nx_count = 5'(w_wr) + {4'b0000, w_accept};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_valid[i]   <= 1'b0;
                r_entry[i]   <= '0;
                r_rs1_rdy[i] <= 1'b0;
                r_rs2_rdy[i] <= 1'b0;
            end
            for (int unsigned k = 0; k < NUM_FU; k++) r_fu_entry[k] <= '0;
            r_fu_enable <= '0;
            r_count     <= '0;
        end else if (bus.flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_valid[i]   <= 1'b0;
                r_entry[i]   <= '0;
                r_rs1_rdy[i] <= 1'b0;
                r_rs2_rdy[i] <= 1'b0;
            end
            for (int unsigned k = 0; k < NUM_FU; k++) r_fu_entry[k] <= '0;
            r_fu_enable <= '0;
            r_count     <= '0;
        end else begin
            r_valid   <= w_nx_valid;
            r_entry   <= w_nx_entry;
            r_rs1_rdy <= w_nx_rs1;
            r_rs2_rdy <= w_nx_rs2;
            r_count   <= w_nx_count;
            for (int unsigned k = 0; k < NUM_FU; k++) begin
                r_fu_enable[k] <= w_sel_vld[k];
                if (w_sel_vld[k]) begin
                    r_fu_entry[k] <= {r_entry[w_sel_idx[k]][ENTRY_W-1:2], 2'(k)};
                end
            end
        end
    end
endmodule
